serial_cla_subtractor: RTL and testbench
========================================

Name: serial_cla_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor computing DIFF = A - B.
- Processes one 4-bit nibble per clock, LSB nibble first.
- Each nibble uses 4-bit carry-lookahead logic on A + ~B with a registered carry chained between nibbles, so only one CLA slice is needed for any word width.
- Sits beside the existing 4-bit CLA adders as the subtract side of the datapath, with a start/ready/done handshake toward the controlling sequencer.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend (unsigned or two's complement)
- b  input  WIDTH  subtrahend
- ready  output  1  block idle and able to accept start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- diff  output  WIDTH  a - b, modulo 2^WIDTH
- borrow_out  output  1  unsigned borrow: 1 when a < b as unsigned
- overflow  output  1  signed overflow of a - b

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State IDLE, so ready=1, busy=0, done=0.
  - diff=0, borrow_out=0, overflow=0.
  - Operand registers, nibble counter and carry register cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - At an edge with start=1, latch a and b into internal registers, set carry register=1 (two's-complement +1), set counter=0, go to RUN.
  - At an edge with start=0, stay in IDLE.
- RUN:
  - busy=1, ready=0.
  - Each edge computes nibble i = counter: {c_out, s[3:0]} = A_i + ~B_i + carry, with P=A^~B, G=A&~B, and lookahead carries C1..C4 exactly as in the 4-bit CLA.
  - s is written into the result shift register at nibble i; carry register <= c_out; counter increments.
  - At the edge where counter = NIB-1, go to DONE and update outputs:
    - diff <= full result.
    - borrow_out <= ~c_out of the top nibble.
    - overflow <= (a_msb != b_msb) && (diff_msb != a_msb), using the latched operands.
- DONE:
  - done=1 for exactly this cycle; busy=0, ready=0.
  - Next edge goes to IDLE unconditionally.
  - start in DONE is ignored, not queued.
- Latency: start sampled at edge k; nibbles processed at edges k+1 .. k+NIB; done=1 during the cycle after edge k+NIB. With WIDTH=16, done is high between edges k+4 and k+5.
- Throughput: a new start is accepted no earlier than edge k+NIB+2 (first IDLE cycle). Back-to-back operations cost NIB+2 cycles each.
- Operand stability: a and b are sampled only at the accepting edge; later changes on a, b or start during RUN/DONE have no effect.
- Output hold: diff, borrow_out and overflow change only at the edge entering DONE and hold until the next entry into DONE. Intermediate nibble results are never visible on diff.
- Width rules: all arithmetic is modulo 2^WIDTH; no saturation. The carry register is 1 bit and persists across nibbles only within one operation.
- Reset mid-operation: asserting rst in RUN or DONE immediately (asynchronously) forces all reset values. No done pulse is produced for the aborted operation. After rst is released, the next start behaves normally.
- Mutual exclusion: ready, busy and done are never high simultaneously; exactly one is high in every cycle after reset.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0234, start pulsed at edge 0 → busy=1 for edges 1–4; done=1 in the cycle after edge 4; diff=0x1000, borrow_out=0, overflow=0; ready=1 after edge 5.
2. a=0x0000, b=0x0001 → diff=0xFFFF, borrow_out=1, overflow=0.
3. a=0x8000, b=0x0001 → diff=0x7FFF, borrow_out=0, overflow=1.
4. a=0x7FFF, b=0xFFFF → diff=0x8000, borrow_out=1, overflow=1. Also a=b=0xA5A5 → diff=0x0000, borrow_out=0, overflow=0.
5. start held high continuously while a/b change every cycle during RUN → only operands present at the accepting edge are used; the next operation is accepted exactly at the first IDLE edge (period NIB+2 = 6 cycles); each done is a single-cycle pulse.
6. rst asserted asynchronously after two RUN edges of 0x1234 - 0x0234 → diff=0, borrow_out=0, overflow=0 and ready=1 immediately, no done pulse. After release, a=0x0010, b=0x0020 → diff=0xFFF0, borrow_out=1, overflow=0.

Source files
------------

// File: rtl/serial_cla_subtractor.sv
// rtl/serial_cla_subtractor.sv - nibble-serial A-B using a single 4-bit CLA slice and a registered carry
module serial_cla_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic             a_msb, b_msb;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [3:0]       na, nb, p, g, c, s;
    logic             c4;

    // Operands shift right one nibble per RUN edge, so the slice always sees bits [3:0]
    always_comb begin
        na   = a_sh[3:0];
        nb   = ~b_sh[3:0];
        p    = na ^ nb;
        g    = na & nb;
        c[0] = carry;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c;
        res_nx = WIDTH'({s, res} >> 4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            res        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        res   <= '0;
                        cnt   <= '0;
                        carry <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    res   <= res_nx;
                    carry <= c4;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= res_nx;
                        borrow_out <= ~c4;
                        overflow   <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cla_subtractor.sv
// tb/tb_serial_cla_subtractor.sv - randomized and directed bench for serial_cla_subtractor
module tb_serial_cla_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             ready, busy, done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out, overflow;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] held_diff = '0;
    logic             held_borrow = 1'b0;
    logic             held_ovf = 1'b0;

    serial_cla_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .busy(busy), .done(done),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         output logic [WIDTH-1:0] d, output logic br, output logic ov);
        int sa, sb, sd;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        sd = sa - sb;
        d  = WIDTH'(int'(av) - int'(bv));
        br = (int'(av) < int'(bv));
        ov = (sd > 32767) || (sd < -32768);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
        logic [WIDTH-1:0] ed;
        logic             eb, eo;
        model(av, bv, ed, eb, eo);
        chk({tag, ".idle"}, {29'd0, ready, busy, done}, 32'b100);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            chk({tag, ".run"}, {29'd0, ready, busy, done}, 32'b010);
            chk({tag, ".hold"}, {14'd0, borrow_out, overflow, diff},
                {14'd0, held_borrow, held_ovf, held_diff});
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            tick();
        end
        chk({tag, ".done"}, {29'd0, ready, busy, done}, 32'b001);
        chk({tag, ".result"}, {14'd0, borrow_out, overflow, diff}, {14'd0, eb, eo, ed});
        held_diff = ed; held_borrow = eb; held_ovf = eo;
        tick();
        chk({tag, ".back_idle"}, {29'd0, ready, busy, done}, 32'b100);
    endtask

    initial begin
        logic [WIDTH-1:0] sa_op, sb_op, ed;
        logic             eb, eo;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick(); tick();
        chk("reset.flags", {29'd0, ready, busy, done}, 32'b100);
        chk("reset.outs", {14'd0, borrow_out, overflow, diff}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(16'h1234, 16'h0234, "t1");
        run_op(16'h0000, 16'h0001, "t2");
        run_op(16'h8000, 16'h0001, "t3");
        run_op(16'h7FFF, 16'hFFFF, "t4a");
        run_op(16'hA5A5, 16'hA5A5, "t4b");
        for (int n = 0; n < 20; n++)
            run_op(WIDTH'($urandom), WIDTH'($urandom), "rand");

        // start held high with operands changing every cycle
        sa_op = '0; sb_op = '0;
        start = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            chk("t5.ready", {31'd0, ready}, {31'd0, (cyc % 6) == 0});
            chk("t5.done", {31'd0, done}, {31'd0, (cyc % 6) == 5});
            if ((cyc % 6) == 5) begin
                model(sa_op, sb_op, ed, eb, eo);
                chk("t5.result", {14'd0, borrow_out, overflow, diff}, {14'd0, eb, eo, ed});
                held_diff = ed; held_borrow = eb; held_ovf = eo;
            end
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            if ((cyc % 6) == 0) begin
                sa_op = a; sb_op = b;
            end
            tick();
        end
        start = 1'b0;

        // asynchronous reset after two RUN edges
        a = 16'h1234; b = 16'h0234; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t6.pre", {29'd0, ready, busy, done}, 32'b010);
        #2 rst = 1'b1;
        #1;
        chk("t6.async_flags", {29'd0, ready, busy, done}, 32'b100);
        chk("t6.async_outs", {14'd0, borrow_out, overflow, diff}, 32'd0);
        held_diff = '0; held_borrow = 1'b0; held_ovf = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NIB + 2; i++) begin
            chk("t6.no_done", {29'd0, ready, busy, done}, 32'b100);
            tick();
        end
        run_op(16'h0010, 16'h0020, "t6b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
